n_bit_div: RTL and testbench

Multi-cycle unsigned restoring divider. It is the inverse of n_bit_mul: it takes a 2*BIT_DEPTH-bit dividend, such as a product from n_bit_mul, and a BIT_DEPTH-bit divisor. It returns a BIT_DEPTH-bit quotient and remainder, one quotient bit per clock. It sits beside n_bit_mul in the arithmetic datapath and uses a start/busy/done handshake.

---
 rtl/n_bit_div_if.sv | 15 +
 rtl/n_bit_div.sv | 126 ++++++++++++
 tb/tb_n_bit_div.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/n_bit_div_if.sv
// Start/busy/done handshake bundle for the n_bit_div unsigned divider.
interface n_bit_div_if #(parameter int BIT_DEPTH = 32);
  logic                   start;
  logic [2*BIT_DEPTH-1:0] a;
  logic [BIT_DEPTH-1:0]   b;
  logic [BIT_DEPTH-1:0]   q;
  logic [BIT_DEPTH-1:0]   r;
  logic                   busy;
  logic                   done;
  logic                   div_zero;
  logic                   ovf;

  modport master (output start, a, b, input q, r, busy, done, div_zero, ovf);
  modport slave  (input start, a, b, output q, r, busy, done, div_zero, ovf);
endinterface

// File: rtl/n_bit_div.sv
// Multi-cycle unsigned restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per clock, with divide-by-zero and overflow detection.
module n_bit_div #(
  parameter int BIT_DEPTH = 32
) (
  input logic          clk,
  input logic          rst,
  n_bit_div_if.slave   bus
);
  localparam int N  = BIT_DEPTH;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE, ERR} state_t;

  state_t          state_r, next_s;
  logic [N-1:0]    div_r, rem_r, lo_r, quo_r;
  logic [CW-1:0]   cnt_r;
  logic [N-1:0]    q_r, r_r;
  logic            busy_r, done_r, div_zero_r, ovf_r;

  logic            accept_s, bad_s, ge_s;
  logic [N:0]      partial_s, diff_s;
  logic [N-1:0]    rem_nxt_s, quo_nxt_s;

  // One restoring step; the compare is N+1 bits so a set partial MSB is never lost.
  always_comb begin
    partial_s = {rem_r, lo_r[N-1]};
    diff_s    = partial_s - {1'b0, div_r};
    ge_s      = (partial_s >= {1'b0, div_r});
    if (ge_s) begin
      rem_nxt_s = diff_s[N-1:0];
    end else begin
      rem_nxt_s = partial_s[N-1:0];
    end
    quo_nxt_s = {quo_r[N-2:0], ge_s};
  end

  // Next-state logic; a start is only taken while not busy.
  always_comb begin
    next_s   = state_r;
    accept_s = 1'b0;
    bad_s    = (bus.b == {N{1'b0}}) || (bus.a[2*N-1:N] >= bus.b);
    case (state_r)
      CALC: begin
        if (cnt_r == CW'(1)) begin
          next_s = DONE;
        end else begin
          next_s = CALC;
        end
      end
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          accept_s = 1'b1;
          next_s   = bad_s ? ERR : CALC;
        end else begin
          next_s   = IDLE;
        end
      end
      default: next_s = IDLE;
    endcase
  end

  // State register and iteration datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      div_r   <= {N{1'b0}};
      rem_r   <= {N{1'b0}};
      lo_r    <= {N{1'b0}};
      quo_r   <= {N{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= next_s;
      if (accept_s) begin
        div_r <= bus.b;
        rem_r <= bus.a[2*N-1:N];
        lo_r  <= bus.a[N-1:0];
        quo_r <= {N{1'b0}};
        cnt_r <= CW'(N);
      end else if (state_r == CALC) begin
        rem_r <= rem_nxt_s;
        lo_r  <= {lo_r[N-2:0], 1'b0};
        quo_r <= quo_nxt_s;
        cnt_r <= cnt_r - CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Registered outputs; results update only when a result is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r        <= {N{1'b0}};
      r_r        <= {N{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      busy_r <= (next_s == CALC);
      if (next_s == DONE) begin
        q_r        <= quo_nxt_s;
        r_r        <= rem_nxt_s;
        done_r     <= 1'b1;
        div_zero_r <= 1'b0;
        ovf_r      <= 1'b0;
      end else if (next_s == ERR) begin
        q_r        <= {N{1'b1}};
        r_r        <= bus.a[N-1:0];
        done_r     <= 1'b1;
        div_zero_r <= (bus.b == {N{1'b0}});
        ovf_r      <= (bus.b != {N{1'b0}});
      end else begin
        done_r     <= 1'b0;
      end
    end
  end

  assign bus.q        = q_r;
  assign bus.r        = r_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign bus.ovf      = ovf_r;
endmodule

// File: tb/tb_n_bit_div.sv
// Directed scoreboard bench for n_bit_div (BIT_DEPTH=32): expected results are
// queued when a start is issued and compared when done pulses.
module tb_n_bit_div;
  localparam int N = 32;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    logic         ovf;
    int           lat;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  n_bit_div_if #(.BIT_DEPTH(N)) bus ();

  n_bit_div #(.BIT_DEPTH(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2*N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a[N-1:0]; e.dz = 1'b1; e.ovf = 1'b0; e.lat = 1;
    end else if (a[2*N-1:N] >= b) begin
      e.q = '1; e.r = a[N-1:0]; e.dz = 1'b0; e.ovf = 1'b1; e.lat = 1;
    end else begin
      e.q = N'(a / {32'd0, b}); e.r = N'(a % {32'd0, b});
      e.dz = 1'b0; e.ovf = 1'b0; e.lat = N + 1;
    end
    return e;
  endfunction

  // Called at a negedge; the following posedge is cycle 0.
  task automatic issue(input logic [2*N-1:0] a, input logic [N-1:0] b);
    sb.push_back(model(a, b));
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom();
    bus.b     = $urandom();
  endtask

  // Waits (bounded) for done starting at cycle cyc0, then checks latency and result.
  task automatic wait_done(input string tag, input int cyc0);
    exp_t e;
    int   cyc;
    cyc = cyc0;
    e   = sb[0];
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (e.lat > 1) chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    chk({tag, "_lat"}, 64'(cyc), 64'(e.lat));
    chk({tag, "_q"}, 64'(bus.q), 64'(e.q));
    chk({tag, "_r"}, 64'(bus.r), 64'(e.r));
    chk({tag, "_dz"}, 64'(bus.div_zero), 64'(e.dz));
    chk({tag, "_ovf"}, 64'(bus.ovf), 64'(e.ovf));
    chk({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [63:0] prod;
    logic        seen_done;
    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_q", 64'(bus.q), 64'd0);
    chk("rst_r", 64'(bus.r), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_flags", 64'({bus.div_zero, bus.ovf}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(64'd9, 32'd3);                         wait_done("t1", 1);
    chk("t1_q_const", 64'(bus.q), 64'd3);
    @(negedge clk);
    chk("t1_done_pulse", 64'(bus.done), 64'd0);
    chk("t1_q_hold", 64'(bus.q), 64'd3);

    issue(64'hFFFFFFFE00000001, 32'hFFFFFFFF);   wait_done("t2a", 1);
    chk("t2a_q_const", 64'(bus.q), 64'hFFFFFFFF);
    prod = 64'd2097120 * 64'd17660;
    issue(prod, 32'd17660);                      wait_done("t2b", 1);
    issue(64'd1000, 32'd7);                      wait_done("t2c", 1);
    chk("t2c_r_const", 64'(bus.r), 64'd6);

    @(negedge clk);
    issue(64'd5, 32'd0);                         wait_done("t3", 1);
    chk("t3_r_const", 64'(bus.r), 64'd5);
    @(negedge clk);
    issue(64'h1_00000000, 32'd1);                wait_done("t4a", 1);
    @(negedge clk);
    issue(64'h0_FFFFFFFF, 32'd1);                wait_done("t4b", 1);

    // Test 5: start ignored while busy, accepted in the DONE cycle.
    @(negedge clk);
    issue(64'd100, 32'd9);
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.a = 64'd50; bus.b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("t5a", 11);
    chk("t5a_q_const", 64'(bus.q), 64'd11);
    issue(64'd50, 32'd5);
    chk("t5_q_hold_busy", 64'(bus.q), 64'd11);
    wait_done("t5b", 1);

    // Test 6: reset mid-operation aborts with no done pulse.
    @(negedge clk);
    issue(64'd100, 32'd9);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_front());
    chk("t6_q", 64'(bus.q), 64'd0);
    chk("t6_r", 64'(bus.r), 64'd0);
    chk("t6_busy", 64'(bus.busy), 64'd0);
    chk("t6_done", 64'(bus.done), 64'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    chk("t6_no_done", 64'(seen_done), 64'd0);
    issue(64'd1000, 32'd7);                      wait_done("t6b", 1);

    // A few random in-range and out-of-range divisions.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      issue({$urandom_range(0, 255) == 0 ? 32'hFFFFFFFF : 32'($urandom_range(0, 1000)),
             32'($urandom())}, 32'($urandom_range(0, 2000)));
      wait_done("rnd", 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
